banco_registradores_contexto: RTL and testbench

//  Parametrised register bank: 2 async read ports, 1 sync write port, hardwired zero register, FP tap.

---
 rtl/banco_registradores_contexto.sv | 124 ++++++++++++
 tb/tb_banco_registradores_contexto.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/banco_registradores_contexto.sv
// banco_registradores_contexto: register bank with context save/restore engine
//
// Register bank with two combinational read ports, one synchronous write port,
// a hardwired-zero register and a frame-pointer tap. A small engine streams the
// whole bank out over a valid/ready channel (save) or reloads it in index order
// from a second valid/ready channel (restore).
//
// Optional feature: define WRITE_BYPASS_EN to forward an accepted write to the
// read ports (and FP) in the same cycle.
//
// Ports:
//   Clock, Reset        rising-edge clock, asynchronous active-low reset
//   Reg1, Reg2          read addresses; Dado1, Dado2 combinational read data
//   RegEscrita, RegWrite, EscreveDado   write port (accepted only in IDLE)
//   FP                  contents of register FP_REG
//   SaveStart, RestoreStart             start requests, sampled in IDLE
//   CtxOutValid/Ready/Addr/Data         save channel (bank is source)
//   CtxInValid/Ready/Data               restore channel (bank is sink)
//   Busy                engine in SAVE or RESTORE
//   Done                one-cycle pulse when an operation completes
module banco_registradores_contexto #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int FP_REG   = 29
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Reg1,
    input  logic [ADDR_W-1:0] Reg2,
    input  logic [ADDR_W-1:0] RegEscrita,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] EscreveDado,
    output logic [DATA_W-1:0] Dado1,
    output logic [DATA_W-1:0] Dado2,
    output logic [DATA_W-1:0] FP,
    input  logic              SaveStart,
    input  logic              RestoreStart,
    output logic              CtxOutValid,
    input  logic              CtxOutReady,
    output logic [ADDR_W-1:0] CtxOutAddr,
    output logic [DATA_W-1:0] CtxOutData,
    input  logic              CtxInValid,
    output logic              CtxInReady,
    input  logic [DATA_W-1:0] CtxInData,
    output logic              Busy,
    output logic              Done
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] FP_A   = ADDR_W'(FP_REG);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_en, rs_en, beat_out, beat_in;
    logic              byp1, byp2, bypf;

    // Pipeline writes only land while the engine is idle; during an operation
    // they are dropped so the saved/restored image stays coherent.
    assign wr_en    = state == IDLE && RegWrite && RegEscrita != ZERO_A;
    assign beat_out = state == SAVE && CtxOutReady;
    assign beat_in  = state == RESTORE && CtxInValid;
    // The zero-register beat is still consumed, its data discarded.
    assign rs_en    = beat_in && idx != ZERO_A;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[RegEscrita] <= EscreveDado;
        end else if (rs_en) begin
            regs[idx] <= CtxInData;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = SaveStart ? SAVE : RestoreStart ? RESTORE : IDLE;
            SAVE:    state_nxt = beat_out && idx == LAST_A ? DONE : SAVE;
            RESTORE: state_nxt = beat_in && idx == LAST_A ? DONE : RESTORE;
            default: state_nxt = IDLE;
        endcase
    end

    // idx restarts from zero only through IDLE, never by wrapping mid-operation.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)                  idx <= '0;
        else if (state == IDLE)      idx <= '0;
        else if (beat_out || beat_in) idx <= idx + 1'b1;
    end

    always_comb begin
        Busy        = state == SAVE || state == RESTORE;
        Done        = state == DONE;
        CtxOutValid = state == SAVE;
        CtxInReady  = state == RESTORE;
        CtxOutAddr  = idx;
        CtxOutData  = idx == ZERO_A ? '0 : regs[idx];
    end

`ifdef WRITE_BYPASS_EN
    assign byp1 = wr_en && RegEscrita == Reg1;
    assign byp2 = wr_en && RegEscrita == Reg2;
    assign bypf = wr_en && RegEscrita == FP_A;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
    assign bypf = 1'b0;
`endif

    assign Dado1 = Reg1 == ZERO_A ? '0 : byp1 ? EscreveDado : regs[Reg1];
    assign Dado2 = Reg2 == ZERO_A ? '0 : byp2 ? EscreveDado : regs[Reg2];
    assign FP    = FP_A == ZERO_A ? '0 : bypf ? EscreveDado : regs[FP_A];
endmodule

// File: tb/tb_banco_registradores_contexto.sv
// tb_banco_registradores_contexto: randomized self-checking bench with array reference model
module tb_banco_registradores_contexto;
    localparam int D = 32;

    logic        Clock = 1'b0, Reset = 1'b1;
    logic [4:0]  Reg1 = '0, Reg2 = '0, RegEscrita = '0, CtxOutAddr;
    logic        RegWrite = 1'b0, SaveStart = 1'b0, RestoreStart = 1'b0;
    logic        CtxOutReady = 1'b0, CtxInValid = 1'b0;
    logic        CtxOutValid, CtxInReady, Busy, Done;
    logic [31:0] EscreveDado = '0, CtxInData = '0;
    logic [31:0] Dado1, Dado2, FP, CtxOutData;

    int          errors = 0, checks = 0;
    logic [31:0] model [D];

    banco_registradores_contexto dut (
        .Clock(Clock), .Reset(Reset), .Reg1(Reg1), .Reg2(Reg2),
        .RegEscrita(RegEscrita), .RegWrite(RegWrite), .EscreveDado(EscreveDado),
        .Dado1(Dado1), .Dado2(Dado2), .FP(FP),
        .SaveStart(SaveStart), .RestoreStart(RestoreStart),
        .CtxOutValid(CtxOutValid), .CtxOutReady(CtxOutReady),
        .CtxOutAddr(CtxOutAddr), .CtxOutData(CtxOutData),
        .CtxInValid(CtxInValid), .CtxInReady(CtxInReady), .CtxInData(CtxInData),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step;
        @(posedge Clock);
        #1;
    endtask

    // Write through the pipeline port while idle; register 31 never changes.
    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        RegWrite = 1'b1; RegEscrita = a; EscreveDado = d;
        step();
        RegWrite = 1'b0;
        if (a != 5'd31) model[a] = d;
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        #3;
        Reg1 = 5'($urandom);
        #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0h exp=0", Done); end
        checks++; if (CtxOutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid got=%0h exp=0", CtxOutValid); end
        checks++; if (CtxInReady !== 1'b0) begin errors++; $display("FAIL reset_inready got=%0h exp=0", CtxInReady); end
        checks++; if (CtxOutAddr !== 5'd0) begin errors++; $display("FAIL reset_outaddr got=%0h exp=0", CtxOutAddr); end
        checks++; if (Dado1 !== 32'd0) begin errors++; $display("FAIL reset_dado1 got=%0h exp=0", Dado1); end
        for (int i = 0; i < D; i++) model[i] = '0;
        step();
        Reset = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_save;
        for (int i = 0; i < 8; i++) write_reg(5'($urandom_range(0, 30)), $urandom | 32'h1);
        write_reg(5'd5, 32'h0BAD_F00D);
        SaveStart = 1'b1;
        step();
        SaveStart = 1'b0;
        CtxOutReady = 1'b1;
        repeat (7) step();
        checks++; if (CtxOutAddr !== 5'd7) begin errors++; $display("FAIL midsave_addr got=%0d exp=7", CtxOutAddr); end
        Reset = 1'b0;
        Reg1 = 5'd5;
        #2;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midsave_busy got=%0h exp=0", Busy); end
        checks++; if (CtxOutValid !== 1'b0) begin errors++; $display("FAIL midsave_outvalid got=%0h exp=0", CtxOutValid); end
        checks++; if (Dado1 !== 32'd0) begin errors++; $display("FAIL midsave_dado1 got=%0h exp=0", Dado1); end
        for (int i = 0; i < D; i++) begin
            Reg2 = 5'(i);
            #1;
            checks++; if (Dado2 !== 32'd0) begin errors++; $display("FAIL midsave_reg%0d got=%0h exp=0", i, Dado2); end
        end
        for (int i = 0; i < D; i++) model[i] = '0;
        CtxOutReady = 1'b0;
        step();
        Reset = 1'b1;
        step();
    endtask

    task automatic test_write_read;
        write_reg(5'd5, 32'hDEAD_BEEF);
        Reg1 = 5'd5;
        #1;
        checks++; if (Dado1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_r5 got=%0h exp=deadbeef", Dado1); end
        write_reg(5'd31, $urandom | 32'h1);
        Reg2 = 5'd31;
        #1;
        checks++; if (Dado2 !== 32'd0) begin errors++; $display("FAIL wr_r31 got=%0h exp=0", Dado2); end
        for (int n = 0; n < 16; n++) begin
            write_reg(5'($urandom), $urandom);
            Reg1 = 5'($urandom);
            Reg2 = 5'($urandom);
            #1;
            checks++; if (Dado1 !== model[Reg1]) begin errors++; $display("FAIL rand_dado1 r%0d got=%0h exp=%0h", Reg1, Dado1, model[Reg1]); end
            checks++; if (Dado2 !== model[Reg2]) begin errors++; $display("FAIL rand_dado2 r%0d got=%0h exp=%0h", Reg2, Dado2, model[Reg2]); end
            checks++; if (FP !== model[29]) begin errors++; $display("FAIL rand_fp got=%0h exp=%0h", FP, model[29]); end
        end
    endtask

    task automatic test_save;
        int beats = 0, dones = 0, post = 0;
        logic held = 1'b0;
        logic [4:0] ha = '0;
        logic [31:0] hd = '0;
        for (int i = 0; i < 31; i++) write_reg(5'(i), 32'(100 + i));
        SaveStart = 1'b1;
        step();
        SaveStart = 1'b0;
        for (int cyc = 0; cyc < 200 && post < 3; cyc++) begin
            CtxOutReady = (cyc % 2) == 0;
            #1;
            if (Done) dones++;
            if (CtxOutValid) begin
                if (beats >= D) begin
                    checks++; errors++; $display("FAIL save_extra_beat got=%0d exp=%0d", beats + 1, D);
                end else begin
                    if (held) begin
                        checks++; if (CtxOutAddr !== ha) begin errors++; $display("FAIL save_hold_addr got=%0d exp=%0d", CtxOutAddr, ha); end
                        checks++; if (CtxOutData !== hd) begin errors++; $display("FAIL save_hold_data got=%0h exp=%0h", CtxOutData, hd); end
                    end
                    checks++; if (CtxOutAddr !== 5'(beats)) begin errors++; $display("FAIL save_addr got=%0d exp=%0d", CtxOutAddr, beats); end
                    checks++; if (CtxOutData !== model[beats]) begin errors++; $display("FAIL save_data idx=%0d got=%0h exp=%0h", beats, CtxOutData, model[beats]); end
                    held = !CtxOutReady; ha = CtxOutAddr; hd = CtxOutData;
                    if (CtxOutReady) beats++;
                end
            end
            if (beats == D && !Busy) post++;
            @(posedge Clock);
            #1;
        end
        CtxOutReady = 1'b0;
        checks++; if (beats !== D) begin errors++; $display("FAIL save_beats got=%0d exp=%0d", beats, D); end
        checks++; if (dones !== 1) begin errors++; $display("FAIL save_done_pulses got=%0d exp=1", dones); end
    endtask

    task automatic test_restore;
        int beats = 0;
        RestoreStart = 1'b1;
        step();
        RestoreStart = 1'b0;
        for (int cyc = 0; cyc < 400 && beats < D; cyc++) begin
            CtxInValid  = 1'($urandom_range(0, 1));
            CtxInData   = 32'(beats * 3);
            RegWrite    = 1'($urandom_range(0, 1));
            RegEscrita  = 5'($urandom);
            EscreveDado = $urandom;
            #1;
            checks++; if (CtxInReady !== 1'b1 || Busy !== 1'b1) begin errors++; $display("FAIL restore_ready got=%0h busy=%0h exp=1", CtxInReady, Busy); end
            if (CtxInValid) begin
                if (beats != 31) model[beats] = 32'(beats * 3);
                beats++;
            end
            step();
        end
        CtxInValid = 1'b0;
        checks++; if (beats !== D) begin errors++; $display("FAIL restore_beats got=%0d exp=%0d", beats, D); end
        RegWrite = 1'b1; RegEscrita = 5'd4; EscreveDado = 32'hFFFF_FFFF;
        #1;
        checks++; if (Done !== 1'b1 || Busy !== 1'b0) begin errors++; $display("FAIL restore_done got=%0h busy=%0h exp=1/0", Done, Busy); end
        step();
        RegWrite = 1'b0;
        #1;
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL restore_done_width got=%0h exp=0", Done); end
        for (int i = 0; i < D; i++) begin
            Reg1 = 5'(i);
            #1;
            checks++; if (Dado1 !== model[i]) begin errors++; $display("FAIL restore_reg%0d got=%0h exp=%0h", i, Dado1, model[i]); end
        end
        checks++; if (FP !== 32'd87) begin errors++; $display("FAIL restore_fp got=%0d exp=87", FP); end
    endtask

    task automatic test_priority;
        SaveStart = 1'b1; RestoreStart = 1'b1;
        step();
        SaveStart = 1'b0; RestoreStart = 1'b0;
        #1;
        checks++; if (CtxOutValid !== 1'b1) begin errors++; $display("FAIL prio_outvalid got=%0h exp=1", CtxOutValid); end
        checks++; if (CtxInReady !== 1'b0) begin errors++; $display("FAIL prio_inready got=%0h exp=0", CtxInReady); end
        CtxOutReady = 1'b1;
        repeat (D) step();
        checks++; if (Done !== 1'b1) begin errors++; $display("FAIL prio_done got=%0h exp=1", Done); end
        SaveStart = 1'b1;
        step();
        checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL done_ignores_start busy=%0h done=%0h exp=0/0", Busy, Done); end
        step();
        SaveStart = 1'b0;
        checks++; if (Busy !== 1'b1 || CtxOutAddr !== 5'd0) begin errors++; $display("FAIL idle_samples_start busy=%0h addr=%0d exp=1/0", Busy, CtxOutAddr); end
        repeat (D) step();
        checks++; if (Done !== 1'b1) begin errors++; $display("FAIL prio_done2 got=%0h exp=1", Done); end
        step();
        CtxOutReady = 1'b0;
    endtask

    task automatic test_bypass;
        logic [31:0] exp;
        write_reg(5'd3, 32'd777);
        RegWrite = 1'b1; RegEscrita = 5'd3; EscreveDado = 32'd55; Reg1 = 5'd3;
        #1;
`ifdef WRITE_BYPASS_EN
        exp = 32'd55;
`else
        exp = model[3];
`endif
        checks++; if (Dado1 !== exp) begin errors++; $display("FAIL bypass_dado1 got=%0d exp=%0d", Dado1, exp); end
        step();
        RegWrite = 1'b0;
        model[3] = 32'd55;
        #1;
        checks++; if (Dado1 !== 32'd55) begin errors++; $display("FAIL bypass_after got=%0d exp=55", Dado1); end
        RegWrite = 1'b1; RegEscrita = 5'd29; EscreveDado = 32'h1234;
        #1;
`ifdef WRITE_BYPASS_EN
        exp = 32'h1234;
`else
        exp = model[29];
`endif
        checks++; if (FP !== exp) begin errors++; $display("FAIL bypass_fp got=%0h exp=%0h", FP, exp); end
        step();
        model[29] = 32'h1234;
        RegEscrita = 5'd31; EscreveDado = $urandom | 32'h1; Reg2 = 5'd31;
        #1;
        checks++; if (Dado2 !== 32'd0) begin errors++; $display("FAIL bypass_zero got=%0h exp=0", Dado2); end
        step();
        RegWrite = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_save();
        test_write_read();
        test_save();
        test_restore();
        test_priority();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
